// File: rtl/vend_change_payout_ctrl_pkg.sv
// Shared vend definitions: coin values in 5c units and the payout FSM state encoding.
package vend_change_payout_ctrl_pkg;

  localparam int unsigned UNIT_CENTS = 5;
  localparam int unsigned AMT_W      = 3;

  // Coin codes double as their value in 5c units
  typedef enum logic [2:0] {
    NICKEL  = 3'd1,
    DIME    = 3'd2,
    QUARTER = 3'd5
  } coin_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_DRIVE,
    ST_WAIT,
    ST_DONE,
    ST_FAULT
  } pay_state_e;

  function automatic logic [AMT_W-1:0] coin_units(input coin_e c);
    return AMT_W'(c);
  endfunction

endpackage

// File: rtl/vend_change_payout_ctrl_hopper_pulse_timer.sv
// Shared hopper timer: one count covers the drive pulse window followed by the coin-sense watchdog.
module hopper_pulse_timer #(
  parameter int PULSE_CYC   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic pulse_active,
  output logic timeout
);

  localparam int TOTAL = PULSE_CYC + TIMEOUT_CYC;
  localparam int CW    = $clog2(TOTAL + 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clock) begin
    if (reset || start) begin
      cnt_reg <= '0;
    end else if (run && (cnt_reg != CW'(TOTAL))) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // pulse_active: the drive line must still be high in the following cycle
  assign pulse_active = (cnt_reg < CW'(PULSE_CYC - 1));
  assign timeout      = (cnt_reg == CW'(TOTAL - 1));

endmodule

// File: rtl/vend_change_payout_ctrl.sv
// Change payout sequencer: greedy dimes-then-nickels, one coin per sense acknowledge, with inventory.
module vend_change_payout_ctrl
  import vend_change_payout_ctrl_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int PULSE_CYC   = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int LOW_NICK    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [2:0]       req_amt,
  output logic             req_ready,
  output logic             hop_nick_drive,
  output logic             hop_dime_drive,
  input  logic             nick_sense,
  input  logic             dime_sense,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_nick,
  input  logic [CNT_W-1:0] load_dime,
  output logic [CNT_W-1:0] nick_cnt,
  output logic [CNT_W-1:0] dime_cnt,
  output logic             busy,
  output logic             done,
  output logic [2:0]       short_amt,
  output logic             jam,
  output logic             exact_change_only,
  input  logic             clr_fault
);

  pay_state_e       state_reg;
  coin_e            sel_reg;
  logic [2:0]       remaining_reg;
  logic [CNT_W-1:0] nick_cnt_reg;
  logic [CNT_W-1:0] dime_cnt_reg;
  logic             nick_drive_reg;
  logic             dime_drive_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [2:0]       short_reg;
  logic             jam_reg;

  logic timer_start;
  logic timer_run;
  logic pulse_active;
  logic timeout;
  logic sel_sense;
  logic sel_cnt_nz;
  logic coin_paid;

  assign timer_start = (state_reg == ST_SELECT);
  assign timer_run   = (state_reg == ST_DRIVE) || (state_reg == ST_WAIT);

  hopper_pulse_timer #(
    .PULSE_CYC   (PULSE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clock        (clock),
    .reset        (reset),
    .start        (timer_start),
    .run          (timer_run),
    .pulse_active (pulse_active),
    .timeout      (timeout)
  );

  // Only the selected hopper's sense counts, and never against an empty counter
  assign sel_sense  = (sel_reg == DIME) ? dime_sense : nick_sense;
  assign sel_cnt_nz = (sel_reg == DIME) ? (dime_cnt_reg != '0) : (nick_cnt_reg != '0);
  assign coin_paid  = sel_sense && sel_cnt_nz;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      sel_reg        <= NICKEL;
      remaining_reg  <= '0;
      nick_cnt_reg   <= '0;
      dime_cnt_reg   <= '0;
      nick_drive_reg <= 1'b0;
      dime_drive_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      short_reg      <= '0;
      jam_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (load_en) begin
            nick_cnt_reg <= load_nick;
            dime_cnt_reg <= load_dime;
          end else if (req_valid) begin
            remaining_reg <= req_amt;
            short_reg     <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= (req_amt == 3'd0) ? ST_DONE : ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (remaining_reg == 3'd0) begin
            state_reg <= ST_DONE;
          end else if ((remaining_reg >= 3'd2) && (dime_cnt_reg != '0)) begin
            sel_reg        <= DIME;
            dime_drive_reg <= 1'b1;
            state_reg      <= ST_DRIVE;
          end else if (nick_cnt_reg != '0) begin
            sel_reg        <= NICKEL;
            nick_drive_reg <= 1'b1;
            state_reg      <= ST_DRIVE;
          end else begin
            short_reg <= remaining_reg;
            state_reg <= ST_DONE;
          end
        end
        ST_DRIVE, ST_WAIT: begin
          if (coin_paid) begin
            nick_drive_reg <= 1'b0;
            dime_drive_reg <= 1'b0;
            remaining_reg  <= remaining_reg - coin_units(sel_reg);
            if (sel_reg == DIME) dime_cnt_reg <= dime_cnt_reg - 1'b1;
            else                 nick_cnt_reg <= nick_cnt_reg - 1'b1;
            state_reg <= ST_SELECT;
          end else if ((state_reg == ST_DRIVE) && !pulse_active) begin
            nick_drive_reg <= 1'b0;
            dime_drive_reg <= 1'b0;
            state_reg      <= ST_WAIT;
          end else if ((state_reg == ST_WAIT) && timeout) begin
            jam_reg   <= 1'b1;
            short_reg <= remaining_reg;
            state_reg <= ST_FAULT;
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        ST_FAULT: begin
          if (clr_fault) begin
            jam_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready         = (state_reg == ST_IDLE) && !load_en;
  assign hop_nick_drive    = nick_drive_reg;
  assign hop_dime_drive    = dime_drive_reg;
  assign nick_cnt          = nick_cnt_reg;
  assign dime_cnt          = dime_cnt_reg;
  assign busy              = busy_reg;
  assign done              = done_reg;
  assign short_amt         = short_reg;
  assign jam               = jam_reg;
  assign exact_change_only = (nick_cnt_reg < CNT_W'(LOW_NICK));

endmodule

// File: tb/tb_vend_change_payout_ctrl.sv
// Directed bench for the change payout sequencer: greedy payout, shortfall, jam, load priority, reset.
module tb_vend_change_payout_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_amt = '0;
  logic       req_ready;
  logic       hop_nick_drive;
  logic       hop_dime_drive;
  logic       nick_sense = 1'b0;
  logic       dime_sense = 1'b0;
  logic       load_en = 1'b0;
  logic [7:0] load_nick = '0;
  logic [7:0] load_dime = '0;
  logic [7:0] nick_cnt;
  logic [7:0] dime_cnt;
  logic       busy;
  logic       done;
  logic [2:0] short_amt;
  logic       jam;
  logic       exact_change_only;
  logic       clr_fault = 1'b0;

  int total  = 0;
  int passed = 0;

  vend_change_payout_ctrl #(
    .CNT_W       (8),
    .PULSE_CYC   (4),
    .TIMEOUT_CYC (64),
    .LOW_NICK    (2)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_amt           (req_amt),
    .req_ready         (req_ready),
    .hop_nick_drive    (hop_nick_drive),
    .hop_dime_drive    (hop_dime_drive),
    .nick_sense        (nick_sense),
    .dime_sense        (dime_sense),
    .load_en           (load_en),
    .load_nick         (load_nick),
    .load_dime         (load_dime),
    .nick_cnt          (nick_cnt),
    .dime_cnt          (dime_cnt),
    .busy              (busy),
    .done              (done),
    .short_amt         (short_amt),
    .jam               (jam),
    .exact_change_only (exact_change_only),
    .clr_fault         (clr_fault)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] n, input logic [7:0] d);
    load_en = 1'b1; load_nick = n; load_dime = d;
    step(1);
    load_en = 1'b0;
  endtask

  task automatic request(input logic [2:0] amt);
    req_valid = 1'b1; req_amt = amt;
    step(1);
    req_valid = 1'b0;
  endtask

  // Wait for a drive, confirm which hopper, acknowledge it and confirm the drive drops
  task automatic pay_coin(input logic is_dime, input string tag);
    int n = 0;
    while (!(hop_nick_drive || hop_dime_drive) && n < 12) begin
      step(1);
      n++;
    end
    check({tag, "_dime_drv"}, 32'(hop_dime_drive), 32'(is_dime));
    check({tag, "_nick_drv"}, 32'(hop_nick_drive), 32'(!is_dime));
    if (is_dime) dime_sense = 1'b1; else nick_sense = 1'b1;
    step(1);
    dime_sense = 1'b0; nick_sense = 1'b0;
    check({tag, "_drop"}, 32'({hop_nick_drive, hop_dime_drive}), 32'd0);
    $display("coin %s dime=%0d nick_cnt=%0d dime_cnt=%0d", tag, is_dime, nick_cnt, dime_cnt);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 12) begin
      step(1);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    int drv_cycles;
    logic saw_done;

    // Reset values
    step(3);
    reset = 1'b0;
    step(1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_jam", 32'(jam), 32'd0);
    check("rst_drv", 32'({hop_nick_drive, hop_dime_drive}), 32'd0);
    check("rst_cnts", 32'({nick_cnt, dime_cnt}), 32'd0);
    check("rst_eco", 32'(exact_change_only), 32'd1);
    check("rst_short", 32'(short_amt), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    $display("reset done");

    // 1: 15c from 10n/10d -> dime, nickel
    load(8'd10, 8'd10);
    check("t1_eco", 32'(exact_change_only), 32'd0);
    request(3'd3);
    check("t1_busy", 32'(busy), 32'd1);
    pay_coin(1'b1, "t1_c1");
    pay_coin(1'b0, "t1_c2");
    wait_done("t1");
    check("t1_short", 32'(short_amt), 32'd0);
    check("t1_nick", 32'(nick_cnt), 32'd9);
    check("t1_dime", 32'(dime_cnt), 32'd9);
    check("t1_busy_end", 32'(busy), 32'd0);
    step(1);
    check("t1_done_pulse", 32'(done), 32'd0);
    $display("test1 amt=3 short=%0d nick=%0d dime=%0d", short_amt, nick_cnt, dime_cnt);

    // 2: 20c from 5n/0d -> four nickels
    load(8'd5, 8'd0);
    request(3'd4);
    pay_coin(1'b0, "t2_c1");
    pay_coin(1'b0, "t2_c2");
    pay_coin(1'b0, "t2_c3");
    pay_coin(1'b0, "t2_c4");
    wait_done("t2");
    check("t2_short", 32'(short_amt), 32'd0);
    check("t2_cnts", 32'({nick_cnt, dime_cnt}), 32'({8'd1, 8'd0}));
    check("t2_eco", 32'(exact_change_only), 32'd1);
    $display("test2 amt=4 short=%0d nick=%0d dime=%0d", short_amt, nick_cnt, dime_cnt);

    // 3: 25c from 1n/1d -> dime, nickel, short by 2
    step(1);
    load(8'd1, 8'd1);
    request(3'd5);
    pay_coin(1'b1, "t3_c1");
    pay_coin(1'b0, "t3_c2");
    wait_done("t3");
    check("t3_short", 32'(short_amt), 32'd2);
    check("t3_cnts", 32'({nick_cnt, dime_cnt}), 32'd0);
    $display("test3 amt=5 short=%0d nick=%0d dime=%0d", short_amt, nick_cnt, dime_cnt);

    // 4: dime never sensed -> jam after 4 drive + 64 wait cycles
    step(1);
    load(8'd3, 8'd3);
    request(3'd2);
    n = 0;
    while (!hop_dime_drive && n < 12) begin step(1); n++; end
    check("t4_drive_seen", 32'(hop_dime_drive), 32'd1);
    n = 0; drv_cycles = 0; saw_done = 1'b0;
    while (!jam && n < 200) begin
      if (hop_dime_drive) drv_cycles++;
      if (done) saw_done = 1'b1;
      step(1);
      n++;
    end
    check("t4_pulse_width", 32'(drv_cycles), 32'd4);
    check("t4_jam_latency", 32'(n), 32'd68);
    check("t4_jam", 32'(jam), 32'd1);
    check("t4_short", 32'(short_amt), 32'd2);
    check("t4_no_done", 32'(saw_done | done), 32'd0);
    check("t4_ready", 32'(req_ready), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_drv", 32'({hop_nick_drive, hop_dime_drive}), 32'd0);
    dime_sense = 1'b1;
    load_en = 1'b1; load_nick = 8'd9; load_dime = 8'd9;
    step(1);
    dime_sense = 1'b0; load_en = 1'b0;
    check("t4_fault_ignore", 32'({nick_cnt, dime_cnt}), 32'({8'd3, 8'd3}));
    clr_fault = 1'b1;
    step(1);
    clr_fault = 1'b0;
    check("t4_clr_jam", 32'(jam), 32'd0);
    check("t4_clr_ready", 32'(req_ready), 32'd1);
    check("t4_clr_busy", 32'(busy), 32'd0);
    $display("test4 jam_after=%0d drive_cycles=%0d short=%0d", n, drv_cycles, short_amt);

    // 5: load wins over same-cycle request; zero request finishes 2 cycles later
    req_valid = 1'b1; req_amt = 3'd1;
    load_en = 1'b1; load_nick = 8'd7; load_dime = 8'd4;
    #1;
    check("t5_ready_load", 32'(req_ready), 32'd0);
    step(1);
    req_valid = 1'b0; load_en = 1'b0;
    check("t5_loaded", 32'({nick_cnt, dime_cnt}), 32'({8'd7, 8'd4}));
    check("t5_not_acc", 32'(busy), 32'd0);
    request(3'd0);
    check("t5_c1_done", 32'(done), 32'd0);
    check("t5_c1_busy", 32'(busy), 32'd1);
    step(1);
    check("t5_c2_done", 32'(done), 32'd1);
    check("t5_c2_busy", 32'(busy), 32'd0);
    step(1);
    check("t5_c3_done", 32'(done), 32'd0);
    $display("test5 load=7n/4d zero request done");

    // 6: reset in the middle of a dime drive
    request(3'd3);
    n = 0;
    while (!hop_dime_drive && n < 12) begin step(1); n++; end
    check("t6_drive_seen", 32'(hop_dime_drive), 32'd1);
    step(1);
    reset = 1'b1;
    step(1);
    check("t6_drv_low", 32'({hop_nick_drive, hop_dime_drive}), 32'd0);
    check("t6_cnts", 32'({nick_cnt, dime_cnt}), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_eco", 32'(exact_change_only), 32'd1);
    saw_done = done;
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (done) saw_done = 1'b1;
    end
    check("t6_no_done", 32'(saw_done), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd1);
    $display("test6 reset mid-drive");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
